counter_seq_ctrl: RTL and testbench

//  Sequencer for the team's 4-bit counter datapath: loads a start value, steps it up or down
//  at a prescaled rate, detects terminal count, then returns to idle. Gives a host FSM or

---
 rtl/counter_seq_ctrl.sv | 133 +++++++++++++
 tb/tb_counter_seq_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: start/stop/done sequencer around a WIDTH-bit up/down counter.
// A run loads a start value, steps it once every DIV clocks toward the terminal
// value (0 when counting down, all ones when counting up), pulses done for one
// cycle, then returns to idle. Fully synchronous, single clock domain.
// Optional feature: define COUNTER_AUTORELOAD_EN to add the auto_reload input,
// which restarts a run from the captured value instead of going idle.

module counter_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic [WIDTH-1:0] load_val,
`ifdef COUNTER_AUTORELOAD_EN
    input  logic             auto_reload,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] LOAD = 2'b01;
    localparam logic [1:0] RUN  = 2'b10;
    localparam logic [1:0] DONE = 2'b11;

    // A 1-bit prescaler is kept even for DIV=1 so the counter never has zero width.
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0]    presc;
    logic [WIDTH-1:0] cap_val;
    logic             cap_dir;

    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [PW-1:0]    presc_nxt;
    logic [WIDTH-1:0] cap_val_nxt;
    logic             cap_dir_nxt;

    logic [WIDTH-1:0] terminal;
    logic [WIDTH-1:0] q_step;
    logic             tick;

    // Terminal value and the one-step-ahead count, both follow the captured direction.
    assign terminal = cap_dir ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    assign q_step   = cap_dir ? q + WIDTH'(1) : q - WIDTH'(1);
    assign tick     = (presc == PW'(DIV - 1));

    assign qbar = ~q;
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Next-state and datapath decode for the four-state sequencer.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves
        // a signal unassigned and no latch is inferred.
        state_nxt   = state;
        q_nxt       = q;
        presc_nxt   = presc;
        cap_val_nxt = cap_val;
        cap_dir_nxt = cap_dir;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    cap_val_nxt = load_val;
                    cap_dir_nxt = dir;
                    state_nxt   = LOAD;
                end
            end
            LOAD: begin
                // The count loads even when the run is being aborted.
                q_nxt     = cap_val;
                presc_nxt = '0;
                if (stop)
                    state_nxt = IDLE;
                else if (cap_val == terminal)
                    state_nxt = DONE;
                else
                    state_nxt = RUN;
            end
            RUN: begin
                if (stop) begin
                    // Abort freezes both q and the prescaler; no step this cycle.
                    state_nxt = IDLE;
                end else if (tick) begin
                    presc_nxt = '0;
                    q_nxt     = q_step;
                    if (q_step == terminal)
                        state_nxt = DONE;
                end else begin
                    presc_nxt = presc + PW'(1);
                end
            end
            DONE: begin
`ifdef COUNTER_AUTORELOAD_EN
                if (auto_reload && !stop)
                    state_nxt = LOAD;
                else
                    state_nxt = IDLE;
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State registers; synchronous reset takes priority over every input.
    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (rst) begin
            state   <= IDLE;
            q       <= '0;
            presc   <= '0;
            cap_val <= '0;
            cap_dir <= 1'b0;
        end else begin
            state   <= state_nxt;
            q       <= q_nxt;
            presc   <= presc_nxt;
            cap_val <= cap_val_nxt;
            cap_dir <= cap_dir_nxt;
        end
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl: one DIV=1 and one DIV=3 instance.
// Each scenario pushes the expected per-cycle (q, state) trace into a scoreboard
// queue as it starts the run, then pops and compares one entry per clock.

module tb_counter_seq_ctrl;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_LOAD = 2'b01;
    localparam logic [1:0] S_RUN  = 2'b10;
    localparam logic [1:0] S_DONE = 2'b11;

    typedef struct {
        logic [3:0] q;
        logic [1:0] st;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start1 = 1'b0;
    logic       start3 = 1'b0;
    logic       stop = 1'b0;
    logic       dir = 1'b0;
    logic [3:0] load_val = 4'h0;
    logic       auto_reload = 1'b0;

    logic [3:0] q1, qbar1, q3, qbar3;
    logic       busy1, done1, busy3, done3;
    logic [1:0] state1, state3;

    exp_t       sb[$];
    int         push_budget;
    logic [3:0] last_q1;
    logic [3:0] last_q3;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    counter_seq_ctrl #(.WIDTH(4), .DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .stop(stop), .dir(dir),
        .load_val(load_val),
`ifdef COUNTER_AUTORELOAD_EN
        .auto_reload(auto_reload),
`endif
        .q(q1), .qbar(qbar1), .busy(busy1), .done(done1), .state(state1)
    );

    counter_seq_ctrl #(.WIDTH(4), .DIV(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .stop(stop), .dir(dir),
        .load_val(load_val),
`ifdef COUNTER_AUTORELOAD_EN
        .auto_reload(auto_reload),
`endif
        .q(q3), .qbar(qbar3), .busy(busy3), .done(done3), .state(state3)
    );

    task automatic push_exp(input logic [3:0] qv, input logic [1:0] st);
        exp_t e;
        if (push_budget > 0) begin
            e.q  = qv;
            e.st = st;
            sb.push_back(e);
            push_budget--;
        end
    endtask

    // Expected trace of one run: LOAD shows the old q, each non-terminal value is
    // held DIV cycles in RUN, the terminal shows once in DONE, then IDLE.
    task automatic push_run(input logic [3:0] prev_q, input logic [3:0] n,
                            input bit up, input int div, input int limit);
        logic [3:0] term;
        logic [3:0] v;
        push_budget = limit;
        term = up ? 4'hF : 4'h0;
        push_exp(prev_q, S_LOAD);
        v = n;
        while (v != term) begin
            for (int k = 0; k < div; k++) push_exp(v, S_RUN);
            v = up ? v + 4'd1 : v - 4'd1;
        end
        push_exp(term, S_DONE);
        push_exp(term, S_IDLE);
        push_budget = 0;
    endtask

    // Scoreboard consumer: one pop and compare per clock. abort_kind 0 = stop,
    // 1 = rst, asserted for the edge after entry abort_idx. hammer drives start
    // whenever the DUT is in RUN or DONE.
    task automatic run_check(input int sel, input int abort_idx, input int abort_kind,
                             input bit hammer, input string name);
        int idx = 0;
        while (sb.size() > 0) begin
            exp_t       e;
            logic [3:0] oq, oqb;
            logic [1:0] ost;
            logic       ob, od;
            @(posedge clk);
            #1;
            e   = sb.pop_front();
            oq  = (sel == 1) ? q1     : q3;
            oqb = (sel == 1) ? qbar1  : qbar3;
            ost = (sel == 1) ? state1 : state3;
            ob  = (sel == 1) ? busy1  : busy3;
            od  = (sel == 1) ? done1  : done3;
            checks++;
            if (oq !== e.q) begin
                errors++;
                $display("FAIL %s[%0d] q: got %h want %h", name, idx, oq, e.q);
            end
            checks++;
            if (oqb !== ~e.q) begin
                errors++;
                $display("FAIL %s[%0d] qbar: got %h want %h", name, idx, oqb, ~e.q);
            end
            checks++;
            if (ost !== e.st) begin
                errors++;
                $display("FAIL %s[%0d] state: got %b want %b", name, idx, ost, e.st);
            end
            checks++;
            if (ob !== (e.st != S_IDLE)) begin
                errors++;
                $display("FAIL %s[%0d] busy: got %b want %b", name, idx, ob, e.st != S_IDLE);
            end
            checks++;
            if (od !== (e.st == S_DONE)) begin
                errors++;
                $display("FAIL %s[%0d] done: got %b want %b", name, idx, od, e.st == S_DONE);
            end
            if (sel == 1) last_q1 = e.q; else last_q3 = e.q;
            start1 = 1'b0;
            start3 = 1'b0;
            stop   = 1'b0;
            rst    = 1'b0;
            if (hammer && (e.st == S_RUN || e.st == S_DONE)) begin
                start1   = 1'b1;
                load_val = 4'h3;
            end
            if (idx == abort_idx) begin
                if (abort_kind == 0) stop = 1'b1;
                else                 rst  = 1'b1;
            end
            idx++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (q1 !== 4'h0 || q3 !== 4'h0) begin
                errors++;
                $display("FAIL reset q: got %h/%h want 0/0", q1, q3);
            end
            checks++;
            if (qbar1 !== 4'hF || qbar3 !== 4'hF) begin
                errors++;
                $display("FAIL reset qbar: got %h/%h want f/f", qbar1, qbar3);
            end
            checks++;
            if (busy1 !== 1'b0 || busy3 !== 1'b0 || done1 !== 1'b0 || done3 !== 1'b0) begin
                errors++;
                $display("FAIL reset busy/done: got %b%b/%b%b want 00/00", busy1, done1, busy3, done3);
            end
            checks++;
            if (state1 !== S_IDLE || state3 !== S_IDLE) begin
                errors++;
                $display("FAIL reset state: got %b/%b want 00/00", state1, state3);
            end
        end
        rst = 1'b0;
        last_q1 = 4'h0;
        last_q3 = 4'h0;
    endtask

    task automatic test_count_down();
        push_run(last_q1, 4'h5, 1'b0, 1, 100);
        load_val = 4'h5; dir = 1'b0; start1 = 1'b1;
        run_check(1, -1, 0, 1'b0, "down5");
    endtask

    task automatic test_count_up_ignore_start();
        push_run(last_q1, 4'hC, 1'b1, 1, 100);
        load_val = 4'hC; dir = 1'b1; start1 = 1'b1;
        run_check(1, -1, 0, 1'b1, "upC");
    endtask

    task automatic test_stop();
        // LOAD, 9..3 = 8 entries; stop while q=3, then IDLE holding 3.
        push_run(last_q1, 4'h9, 1'b0, 1, 8);
        push_budget = 1;
        push_exp(4'h3, S_IDLE);
        load_val = 4'h9; dir = 1'b0; start1 = 1'b1;
        run_check(1, 7, 0, 1'b0, "stop");
    endtask

    task automatic test_load_terminal();
        push_run(last_q1, 4'h0, 1'b0, 1, 100);
        load_val = 4'h0; dir = 1'b0; start1 = 1'b1;
        run_check(1, -1, 0, 1'b0, "load0");
    endtask

    task automatic test_prescale();
        push_run(last_q3, 4'h2, 1'b0, 3, 100);
        load_val = 4'h2; dir = 1'b0; start3 = 1'b1;
        run_check(3, -1, 0, 1'b0, "div3");
    endtask

    task automatic test_reset_midrun();
        // LOAD, 9, 8, 7, 6 = 5 entries; reset while q=6, then q=0 and IDLE.
        push_run(last_q1, 4'h9, 1'b0, 1, 5);
        push_budget = 1;
        push_exp(4'h0, S_IDLE);
        load_val = 4'h9; dir = 1'b0; start1 = 1'b1;
        run_check(1, 4, 1, 1'b0, "rstmid");
        last_q3 = 4'h0;
    endtask

    task automatic test_back_to_back();
        // Start again on the very cycle the previous run reports IDLE.
        push_run(last_q1, 4'hD, 1'b1, 1, 100);
        load_val = 4'hD; dir = 1'b1; start1 = 1'b1;
        run_check(1, -1, 0, 1'b0, "b2b_a");
        push_run(last_q1, 4'h1, 1'b0, 1, 100);
        load_val = 4'h1; dir = 1'b0; start1 = 1'b1;
        run_check(1, -1, 0, 1'b0, "b2b_b");
    endtask

`ifdef COUNTER_AUTORELOAD_EN
    task automatic test_autoreload();
        // Two full terminal counts back to back, stop during the second DONE.
        push_run(last_q1, 4'h2, 1'b0, 1, 4);
        push_run(4'h0, 4'h2, 1'b0, 1, 4);
        push_budget = 1;
        push_exp(4'h0, S_IDLE);
        auto_reload = 1'b1;
        load_val = 4'h2; dir = 1'b0; start1 = 1'b1;
        run_check(1, 7, 0, 1'b0, "reload");
        auto_reload = 1'b0;
    endtask
`endif

    initial begin
        last_q1 = 4'h0;
        last_q3 = 4'h0;
        push_budget = 0;
        @(negedge clk);
        test_reset();
        test_count_down();
        test_count_up_ignore_start();
        test_stop();
        test_load_terminal();
        test_prescale();
        test_reset_midrun();
        test_back_to_back();
`ifdef COUNTER_AUTORELOAD_EN
        test_autoreload();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case a scenario ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
